// File: rtl/conv_pkg.sv
// Shared types, default kernels and arithmetic helpers for the streaming 2-D convolution path.
package conv_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned COEF_W = 5;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    localparam int LAPLACIAN_3 [9] = '{
        -1, -1, -1,
        -1,  8, -1,
        -1, -1, -1
    };

    localparam int LAPLACIAN_5 [25] = '{
        -1, -1, -1, -1, -1,
        -1, -1, -1, -1, -1,
        -1, -1, 24, -1, -1,
        -1, -1, -1, -1, -1,
        -1, -1, -1, -1, -1
    };

    function automatic int unsigned sum_width(input int unsigned word_w, input int unsigned coef_w,
                                              input int unsigned k);
        return word_w + coef_w + 1 + $clog2(k * k);
    endfunction

    function automatic int default_coef(input int unsigned k, input int unsigned idx);
        if (k == 5)
            return LAPLACIAN_5[idx];
        return LAPLACIAN_3[idx];
    endfunction

    function automatic logic [31:0] clamp_to_pix(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] maxv;
        maxv = (64'sd1 <<< w) - 64'sd1;
        if (v < 0)
            return '0;
        else if (v > maxv)
            return maxv[31:0];
        return v[31:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// KERNEL_DIM-1 row delay lines plus a KxK window shift register; both advance only when en is high.
module conv_line_buffer #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned MAX_ROW    = 1024
) (
    input  logic                                          clk,
    input  logic                                          en,
    input  logic [$clog2(MAX_ROW)-1:0]                    addr,
    input  logic [WORD_SIZE-1:0]                          pixel,
    output logic [KERNEL_DIM*KERNEL_DIM*WORD_SIZE-1:0]    window
);

    localparam int unsigned K = KERNEL_DIM;

    logic [WORD_SIZE-1:0] mem [K-1][MAX_ROW];
    logic [WORD_SIZE-1:0] win [K][K];
    logic [WORD_SIZE-1:0] column [K];

    // The row length is set by where the caller wraps addr (the column counter);
    // row i holds the pixel from i+1 rows above at the same column.
    always_comb begin
        column[K-1] = pixel;
        for (int unsigned i = 0; i < K - 1; i++)
            column[K-2-i] = mem[i][addr];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0][addr] <= pixel;
            for (int unsigned i = 1; i < K - 1; i++)
                mem[i][addr] <= mem[i-1][addr];
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= column[r];
            end
        end
    end

    // Window including the pixel being accepted now, row-major from the oldest row.
    always_comb begin
        window = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++)
                window[(r*K+c)*WORD_SIZE +: WORD_SIZE] = win[r][c+1];
            window[(r*K+K-1)*WORD_SIZE +: WORD_SIZE] = column[r];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution with valid/ready, runtime frame size, normalising shift and frame-end marker.
// Optional CONV_KERNEL_LOAD_EN: runtime-loadable coefficient bank via k_we/k_addr/k_data.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned COEF_W     = 5,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned MAX_ROW    = 1024,
    parameter int unsigned MAX_COL    = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [$clog2(MAX_ROW):0]                    cfg_width,
    input  logic [$clog2(MAX_COL):0]                    cfg_height,
    input  logic [4:0]                                  cfg_shift,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [WORD_SIZE-1:0]                        in_pixel,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [WORD_SIZE-1:0]                        out_pixel,
    output logic                                        out_last,
    input  logic                                        k_we,
    input  logic [$clog2(KERNEL_DIM*KERNEL_DIM)-1:0]    k_addr,
    input  logic signed [COEF_W-1:0]                    k_data
);

    localparam int unsigned KK   = KERNEL_DIM * KERNEL_DIM;
    localparam int unsigned KAW  = $clog2(KK);
    localparam int unsigned RW   = $clog2(MAX_ROW) + 1;
    localparam int unsigned CW   = $clog2(MAX_COL) + 1;
    localparam int unsigned AW   = $clog2(MAX_ROW);
    // The 5x5 default centre (24) needs 6 signed bits, so the bank is widened when required.
    localparam int unsigned CF_W   = (KERNEL_DIM == 5 && COEF_W < 6) ? 6 : COEF_W;
    localparam int unsigned PROD_W = WORD_SIZE + CF_W + 1;
    localparam int unsigned SUM_W  = sum_width(WORD_SIZE, CF_W, KERNEL_DIM);

    if (KERNEL_DIM != 3 && KERNEL_DIM != 5) begin : g_bad_kernel
        $error("conv2d_stream: KERNEL_DIM must be 3 or 5");
    end

    logic [RW-1:0] col, width_q, eff_w;
    logic [CW-1:0] row, height_q, eff_h;
    logic [4:0]    shift_q, eff_sh;
    logic          en, accept, frame_start, col_end, row_end, win_ok;

    assign en          = !(out_valid && !out_ready);
    assign in_ready    = en;
    assign accept      = in_valid && en;
    assign frame_start = (row == '0) && (col == '0);
    assign eff_w       = frame_start ? cfg_width  : width_q;
    assign eff_h       = frame_start ? cfg_height : height_q;
    assign eff_sh      = frame_start ? cfg_shift  : shift_q;
    assign col_end     = (col == eff_w - RW'(1));
    assign row_end     = (row == eff_h - CW'(1));
    assign win_ok      = (row >= CW'(KERNEL_DIM - 1)) && (col >= RW'(KERNEL_DIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            width_q  <= '0;
            height_q <= '0;
            shift_q  <= '0;
        end else if (accept) begin
            if (frame_start) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                shift_q  <= cfg_shift;
            end
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + CW'(1);
            end else begin
                col <= col + RW'(1);
            end
        end
    end

    logic [KK*WORD_SIZE-1:0] window;

    conv_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .KERNEL_DIM(KERNEL_DIM),
        .MAX_ROW   (MAX_ROW)
    ) u_line_buffer (
        .clk   (clk),
        .en    (accept),
        .addr  (col[AW-1:0]),
        .pixel (in_pixel),
        .window(window)
    );

    logic signed [CF_W-1:0] kern [KK];

`ifdef CONV_KERNEL_LOAD_EN
    logic signed [CF_W-1:0] shadow [KK];

    // A write coinciding with the frame-start copy reaches the shadow only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < KK; i++) begin
                shadow[i] <= CF_W'(default_coef(KERNEL_DIM, i));
                kern[i]   <= CF_W'(default_coef(KERNEL_DIM, i));
            end
        end else begin
            if (k_we && k_addr < KAW'(KK))
                shadow[k_addr] <= CF_W'(k_data);
            if (accept && frame_start)
                kern <= shadow;
        end
    end
`else
    logic unused_k;
    assign unused_k = ^{k_we, k_addr, k_data};

    always_comb begin
        for (int unsigned i = 0; i < KK; i++)
            kern[i] = CF_W'(default_coef(KERNEL_DIM, i));
    end
`endif

    logic signed [PROD_W-1:0] prod_n [KK];
    logic signed [PROD_W-1:0] prod   [KK];
    logic signed [SUM_W-1:0]  sum_n, sum_q, shifted;
    logic [4:0]               sh1, sh2;
    logic                     v1, v2, last1, last2;
    logic [WORD_SIZE-1:0]     res_n;

    always_comb begin
        for (int unsigned i = 0; i < KK; i++)
            prod_n[i] = PROD_W'($signed({1'b0, window[i*WORD_SIZE +: WORD_SIZE]})) * PROD_W'(kern[i]);
    end

    always_comb begin
        sum_n = '0;
        for (int unsigned i = 0; i < KK; i++)
            sum_n = sum_n + SUM_W'(prod[i]);
    end

    assign shifted = sum_q >>> sh2;
    assign res_n   = WORD_SIZE'(clamp_to_pix(64'(shifted), WORD_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            last1     <= 1'b0;
            last2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pixel <= '0;
        end else if (en) begin
            v1        <= accept && win_ok;
            last1     <= accept && row_end && col_end;
            v2        <= v1;
            last2     <= last1;
            out_valid <= v2;
            out_last  <= v2 && last2;
            out_pixel <= v2 ? res_n : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            prod  <= prod_n;
            sh1   <= eff_sh;
            sum_q <= sum_n;
            sh2   <= sh1;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: directed frames plus randomized frames against a window-sum model.
module tb_conv2d_stream;

    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cfg_width, cfg_height;
    logic [4:0]  cfg_shift;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, k_we;
    logic [7:0]  in_pixel, out_pixel;
    logic [3:0]  k_addr;
    logic signed [4:0] k_data;

    conv2d_stream #(
        .WORD_SIZE (8),
        .COEF_W    (5),
        .KERNEL_DIM(K),
        .MAX_ROW   (1024),
        .MAX_COL   (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_width (cfg_width),
        .cfg_height(cfg_height),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .k_we      (k_we),
        .k_addr    (k_addr),
        .k_data    (k_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit last;
    } ob_t;

    ob_t got_q[$];
    ob_t exp_q[$];
    int  pix_mem [64];
    int  kern_m [9];
    int  n_cmp = 0;
    int  n_mis = 0;
    int  timeouts = 0;
    int  ready_viol = 0;

    always @(negedge clk)
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back('{int'(out_pixel), out_last});

    function automatic void set_laplacian();
        for (int i = 0; i < 9; i++) kern_m[i] = (i == 4) ? 8 : -1;
    endfunction

    // Every full KxK window, raster order, no padding; result = clamp(sum >>> shift).
    function automatic void model(input int w, input int h, input int sh);
        exp_q.delete();
        for (int r = K - 1; r < h; r++)
            for (int c = K - 1; c < w; c++) begin
                int s = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += kern_m[i*K+j] * pix_mem[(r-K+1+i)*w + (c-K+1+j)];
                s = s >>> sh;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                exp_q.push_back('{s, (r == h - 1 && c == w - 1)});
            end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int first, input int last_i, input int w, input int h,
                         input int sh, input bit rnd);
        int  idx = first;
        int  waitc = 0;
        bit  acc;
        while (idx <= last_i) begin
            in_valid = 1'b1;
            in_pixel = 8'(pix_mem[idx]);
            if (idx == 0) begin
                cfg_width  = 11'(w);
                cfg_height = 11'(h);
                cfg_shift  = 5'(sh);
            end else begin
                cfg_width  = 11'($urandom_range(1, 1024));
                cfg_height = 11'($urandom_range(1, 1024));
                cfg_shift  = 5'($urandom);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_ready !== !(out_valid && !out_ready)) ready_viol++;
            acc = in_ready;
            step();
            if (acc) begin
                idx++;
                waitc = 0;
            end else if (++waitc > 200) begin
                timeouts++;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_mis++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_cmp++; if (out_pixel !== 8'd0) begin n_mis++; $display("FAIL reset_out_pixel got %0d want 0", out_pixel); end
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_flat();
        for (int i = 0; i < 25; i++) pix_mem[i] = 100;
        got_q.delete();
        drive(0, 24, 5, 5, 0, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() !== 9) begin n_mis++; $display("FAIL flat_count got %0d want 9", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 9; i++) begin
            n_cmp++;
            if (got_q[i].val !== 0 || got_q[i].last !== (i == 8)) begin
                n_mis++;
                $display("FAIL flat_out[%0d] got %0d/%b want 0/%b", i, got_q[i].val, got_q[i].last, i == 8);
            end
        end
    endtask

    task automatic test_impulse();
        int shifts [3] = '{0, 3, 4};
        int cent   [3] = '{255, 255, 127};
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 25; i++) pix_mem[i] = 0;
            pix_mem[12] = 255;
            got_q.delete();
            drive(0, 24, 5, 5, shifts[t], 1'b0);
            drain();
            n_cmp++;
            if (got_q.size() !== 9) begin n_mis++; $display("FAIL impulse_count sh=%0d got %0d want 9", shifts[t], got_q.size()); end
            for (int i = 0; i < got_q.size() && i < 9; i++) begin
                int want = (i == 4) ? cent[t] : 0;
                n_cmp++;
                if (got_q[i].val !== want || got_q[i].last !== (i == 8)) begin
                    n_mis++;
                    $display("FAIL impulse_out sh=%0d [%0d] got %0d/%b want %0d/%b",
                             shifts[t], i, got_q[i].val, got_q[i].last, want, i == 8);
                end
            end
        end
    endtask

    task automatic test_small_frames();
        for (int i = 0; i < 10; i++) pix_mem[i] = $urandom_range(0, 255);
        got_q.delete();
        drive(0, 9, 2, 5, 0, 1'b0);
        drive(0, 9, 5, 2, 0, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() !== 0) begin n_mis++; $display("FAIL small_frame_count got %0d want 0", got_q.size()); end
        for (int i = 0; i < 16; i++) pix_mem[i] = $urandom_range(0, 255);
        got_q.delete();
        drive(0, 15, 4, 4, 1, 1'b0);
        drain();
        model(4, 4, 1);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL after_small_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].val !== exp_q[i].val || got_q[i].last !== exp_q[i].last) begin
                n_mis++;
                $display("FAIL after_small[%0d] got %0d/%b want %0d/%b", i, got_q[i].val, got_q[i].last, exp_q[i].val, exp_q[i].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sh = $urandom_range(0, 2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                pix_mem[r*8+c] = r * 30 + c * 12 + $urandom_range(0, 40);
        ready_viol = 0;
        timeouts   = 0;
        got_q.delete();
        drive(0, 31, 8, 4, sh, 1'b1);
        drain();
        model(8, 4, sh);
        n_cmp++;
        if (got_q.size() !== 12) begin n_mis++; $display("FAIL stall_count got %0d want 12", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].val !== exp_q[i].val || got_q[i].last !== exp_q[i].last) begin
                n_mis++;
                $display("FAIL stall_out[%0d] got %0d/%b want %0d/%b", i, got_q[i].val, got_q[i].last, exp_q[i].val, exp_q[i].last);
            end
        end
        n_cmp++;
        if (ready_viol !== 0) begin n_mis++; $display("FAIL in_ready_vs_stall got %0d bad cycles want 0", ready_viol); end
        n_cmp++;
        if (timeouts !== 0) begin n_mis++; $display("FAIL stall_accept_timeout got %0d want 0", timeouts); end
    endtask

    task automatic test_reset_midframe();
        int sh;
        for (int i = 0; i < 64; i++) pix_mem[i] = $urandom_range(0, 255);
        got_q.delete();
        drive(0, 19, 8, 8, 0, 1'b0);
        rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        step();
        rst = 1'b0;
        drain();
        n_cmp++;
        if (got_q.size() !== 0) begin n_mis++; $display("FAIL midreset_inflight got %0d outputs want 0", got_q.size()); end
        sh = $urandom_range(0, 3);
        for (int i = 0; i < 64; i++) pix_mem[i] = $urandom_range(0, 255);
        got_q.delete();
        timeouts = 0;
        drive(0, 63, 8, 8, sh, 1'b0);
        drain();
        model(8, 8, sh);
        n_cmp++;
        if (got_q.size() !== 36) begin n_mis++; $display("FAIL fresh_frame_count got %0d want 36", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].val !== exp_q[i].val || got_q[i].last !== exp_q[i].last) begin
                n_mis++;
                $display("FAIL fresh_frame[%0d] got %0d/%b want %0d/%b", i, got_q[i].val, got_q[i].last, exp_q[i].val, exp_q[i].last);
            end
        end
        n_cmp++;
        if (timeouts !== 0) begin n_mis++; $display("FAIL fresh_frame_timeout got %0d want 0", timeouts); end
    endtask

    task automatic test_kernel_load();
        for (int i = 0; i < 25; i++) pix_mem[i] = $urandom_range(0, 255);
        got_q.delete();
        drive(0, 9, 5, 5, 0, 1'b0);
        for (int a = 0; a < 9; a++) begin
            k_we   = 1'b1;
            k_addr = 4'(a);
            k_data = (a == 4) ? 5'sd1 : 5'sd0;
            step();
        end
        k_we = 1'b0;
        drive(10, 24, 5, 5, 0, 1'b0);
        drain();
        model(5, 5, 0);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL kload_frame1_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].val !== exp_q[i].val || got_q[i].last !== exp_q[i].last) begin
                n_mis++;
                $display("FAIL kload_frame1[%0d] got %0d/%b want %0d/%b", i, got_q[i].val, got_q[i].last, exp_q[i].val, exp_q[i].last);
            end
        end
        for (int i = 0; i < 25; i++) pix_mem[i] = $urandom_range(0, 255);
`ifdef CONV_KERNEL_LOAD_EN
        for (int i = 0; i < 9; i++) kern_m[i] = (i == 4) ? 1 : 0;
`endif
        got_q.delete();
        drive(0, 24, 5, 5, 0, 1'b0);
        drain();
        model(5, 5, 0);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL kload_frame2_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].val !== exp_q[i].val || got_q[i].last !== exp_q[i].last) begin
                n_mis++;
                $display("FAIL kload_frame2[%0d] got %0d/%b want %0d/%b", i, got_q[i].val, got_q[i].last, exp_q[i].val, exp_q[i].last);
            end
        end
        set_laplacian();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        cfg_width  = '0;
        cfg_height = '0;
        cfg_shift  = '0;
        in_valid   = 1'b0;
        in_pixel   = '0;
        out_ready  = 1'b1;
        k_we       = 1'b0;
        k_addr     = '0;
        k_data     = '0;
        set_laplacian();
        test_reset();
        test_flat();
        test_impulse();
        test_small_frames();
        test_back_to_back();
        test_reset_midframe();
        test_kernel_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
